// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: instruction-memory port, pipeline redirect/stall inputs and decoded fetch outputs.
// master = fetch stage, slave = surrounding pipeline and instruction memory.
interface fetch_stage_if;
  logic        f_stall;
  logic [3:0]  M_icode;
  logic        M_cnd;
  logic [63:0] M_valA;
  logic [3:0]  W_icode;
  logic [63:0] W_valM;

  logic [63:0] imem_addr;
  logic [79:0] imem_data;
  logic        imem_error;

  logic        f_valid;
  logic [1:0]  f_stat;
  logic [3:0]  f_icode;
  logic [3:0]  f_ifun;
  logic [3:0]  f_rA;
  logic [3:0]  f_rB;
  logic [63:0] f_valC;
  logic [63:0] f_valP;
  logic [63:0] f_predPC;

  modport master (
    input  f_stall, M_icode, M_cnd, M_valA, W_icode, W_valM, imem_data, imem_error,
    output imem_addr, f_valid, f_stat, f_icode, f_ifun, f_rA, f_rB, f_valC, f_valP, f_predPC
  );

  modport slave (
    output f_stall, M_icode, M_cnd, M_valA, W_icode, W_valM, imem_data, imem_error,
    input  imem_addr, f_valid, f_stat, f_icode, f_ifun, f_rA, f_rB, f_valC, f_valP, f_predPC
  );
endinterface

// File: rtl/fetch_stage.sv
// Y86-64 fetch: PC select, field split, valP/predPC and status; zero-cycle from imem_data to outputs.
// f_stall freezes predPC and mode only; outputs always reflect the currently selected PC.
module fetch_stage #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.master bus
);

  typedef enum logic {RUN, HALT} modeT;

  localparam logic [1:0] STAT_AOK = 2'd0;
  localparam logic [1:0] STAT_HLT = 2'd1;
  localparam logic [1:0] STAT_ADR = 2'd2;
  localparam logic [1:0] STAT_INS = 2'd3;

  localparam logic [3:0] I_HALT = 4'h0;
  localparam logic [3:0] I_NOP  = 4'h1;
  localparam logic [3:0] I_JXX  = 4'h7;
  localparam logic [3:0] I_CALL = 4'h8;
  localparam logic [3:0] I_RET  = 4'h9;
  localparam logic [3:0] R_NONE = 4'hF;

  logic [63:0] predPC;
  modeT        mode;

  logic        mispredict;
  logic        retRedirect;
  logic        redirect;
  logic [63:0] fPc;
  logic [7:0]  byte0;
  logic [7:0]  byte1;
  logic [3:0]  icode;
  logic [3:0]  ifun;
  logic        instrInvalid;
  logic        needRegids;
  logic        needValC;
  logic [63:0] valC;
  logic [63:0] valP;
  logic [63:0] predNext;
  logic [1:0]  stat;
  logic        active;

  // Mispredict recovery outranks ret so a squashed ret never steers fetch.
  assign mispredict  = (bus.M_icode == I_JXX) && !bus.M_cnd;
  assign retRedirect = (bus.W_icode == I_RET);
  assign redirect    = mispredict || retRedirect;
  assign fPc         = mispredict  ? bus.M_valA :
                       retRedirect ? bus.W_valM : predPC;

  assign byte0 = bus.imem_data[7:0];
  assign byte1 = bus.imem_data[15:8];
  assign icode = bus.imem_error ? I_NOP : byte0[7:4];
  assign ifun  = bus.imem_error ? 4'h0  : byte0[3:0];

  assign instrInvalid = (icode > 4'hB);

  always_comb begin
    needRegids = 1'b0;
    needValC   = 1'b0;
    case (icode)
      4'h2, 4'h6, 4'hA, 4'hB: needRegids = 1'b1;
      4'h3, 4'h4, 4'h5: begin
        needRegids = 1'b1;
        needValC   = 1'b1;
      end
      4'h7, 4'h8: needValC = 1'b1;
      default: ;
    endcase
  end

  assign valC = !needValC ? 64'h0 :
                needRegids ? bus.imem_data[79:16] : bus.imem_data[71:8];

  assign valP = fPc + 64'd1 + {63'd0, needRegids} + (needValC ? 64'd8 : 64'd0);

  assign predNext = ((icode == I_JXX) || (icode == I_CALL)) ? valC : valP;

  always_comb begin
    if (bus.imem_error)       stat = STAT_ADR;
    else if (instrInvalid)    stat = STAT_INS;
    else if (icode == I_HALT) stat = STAT_HLT;
    else                      stat = STAT_AOK;
  end

  // A redirect squashes the path that halted, so it revives fetch in the same cycle.
  assign active = (mode == RUN) || redirect;

  assign bus.imem_addr = fPc;
  assign bus.f_valid   = active;
  assign bus.f_stat    = active ? stat  : STAT_AOK;
  assign bus.f_icode   = active ? icode : I_NOP;
  assign bus.f_ifun    = active ? ifun  : 4'h0;
  assign bus.f_rA      = (active && needRegids) ? byte1[7:4] : R_NONE;
  assign bus.f_rB      = (active && needRegids) ? byte1[3:0] : R_NONE;
  assign bus.f_valC    = active ? valC : 64'h0;
  assign bus.f_valP    = valP;
  assign bus.f_predPC  = active ? predNext : predPC;

  always_ff @(posedge clk) begin
    if (rst) begin
      predPC <= RESET_PC;
      mode   <= RUN;
    end else if (!bus.f_stall && active) begin
      predPC <= predNext;
      mode   <= (stat == STAT_AOK) ? RUN : HALT;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a randomized redirect/stall stream
// checked against an instruction-length reference model and a sparse byte memory.
module tb_fetch_stage;
  localparam logic [63:0] RPC = 64'h100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_stage_if bus();

  fetch_stage #(.RESET_PC(RPC)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0]   mem [logic [63:0]];
  logic [63:0]  mPred = 64'h0;
  bit           mHalt = 1'b0;
  logic [274:0] expFull;
  logic [70:0]  expShort;
  bit           expActive;

  // Unwritten bytes read back as nop so stray fetches stay benign.
  function automatic logic [7:0] rdByte(input logic [63:0] a);
    return mem.exists(a) ? mem[a] : 8'h10;
  endfunction

  function automatic bit isErr(input logic [63:0] a);
    return a[63:60] == 4'hE;
  endfunction

  function automatic logic [79:0] fetch10(input logic [63:0] a);
    logic [79:0] d;
    for (int k = 0; k < 10; k++) d[8*k +: 8] = rdByte(a + 64'(k));
    return d;
  endfunction

  function automatic logic [274:0] actFull();
    return {bus.f_valid, bus.f_stat, bus.f_icode, bus.f_ifun, bus.f_rA, bus.f_rB,
            bus.f_valC, bus.f_valP, bus.f_predPC, bus.imem_addr};
  endfunction

  function automatic logic [70:0] actShort();
    return {bus.f_valid, bus.f_stat, bus.f_icode, bus.imem_addr};
  endfunction

  task automatic putBytes(input logic [63:0] a, input logic [79:0] d, input int n);
    for (int k = 0; k < n; k++) mem[a + 64'(k)] = d[8*k +: 8];
  endtask

  // Drives one cycle, serves memory, computes the expected outputs and advances the model.
  task automatic applyCycle(input bit r, input bit stall, input logic [3:0] mi, input bit mc,
                            input logic [63:0] mva, input logic [3:0] wi, input logic [63:0] wvm);
    logic [63:0] pc, vc, vp, nxt;
    logic [7:0]  b [10];
    logic [3:0]  ic, fn, ra, rb;
    logic [1:0]  st;
    bit          err, regs, word, mis, rt;
    int          off;
    @(negedge clk);
    rst         = r;
    bus.f_stall = stall;
    bus.M_icode = mi;
    bus.M_cnd   = mc;
    bus.M_valA  = mva;
    bus.W_icode = wi;
    bus.W_valM  = wvm;
    #1;
    bus.imem_data  = fetch10(bus.imem_addr);
    bus.imem_error = isErr(bus.imem_addr);
    #1;
    mis = (mi == 4'h7) && !mc;
    rt  = (wi == 4'h9);
    pc  = mis ? mva : (rt ? wvm : mPred);
    expActive = !mHalt || mis || rt;
    err = isErr(pc);
    for (int k = 0; k < 10; k++) b[k] = rdByte(pc + 64'(k));
    ic   = err ? 4'h1 : b[0][7:4];
    fn   = err ? 4'h0 : b[0][3:0];
    regs = 16'h0C7C >> ic;
    word = 16'h01B8 >> ic;
    ra   = regs ? b[1][7:4] : 4'hF;
    rb   = regs ? b[1][3:0] : 4'hF;
    off  = regs ? 2 : 1;
    vc   = 64'h0;
    if (word) for (int k = 0; k < 8; k++) vc = vc + (64'(b[off + k]) << (8 * k));
    vp   = pc + 64'(1 + int'(regs) + 8 * int'(word));
    nxt  = (ic == 4'h7 || ic == 4'h8) ? vc : vp;
    st   = err ? 2'd2 : (ic > 4'hB) ? 2'd3 : (ic == 4'h0) ? 2'd1 : 2'd0;
    expFull  = {1'b1, st, ic, fn, ra, rb, vc, vp, nxt, pc};
    expShort = expActive ? {1'b1, st, ic, pc} : {1'b0, 2'd0, 4'h1, pc};
    if (r) begin
      mPred = RPC;
      mHalt = 1'b0;
    end else if (!stall && expActive) begin
      mPred = nxt;
      mHalt = (st != 2'd0);
    end
  endtask

  task automatic idle(input bit stall);
    applyCycle(1'b0, stall, 4'h0, 1'b1, 64'h0, 4'h0, 64'h0);
  endtask

  task automatic jumpTo(input bit stall, input logic [63:0] a);
    applyCycle(1'b0, stall, 4'h7, 1'b0, a, 4'h0, 64'h0);
  endtask

  task automatic test_reset();
    putBytes(64'h100, 80'h1122334455667788F330, 10);
    applyCycle(1'b1, 1'b0, 4'h0, 1'b0, 64'h0, 4'h0, 64'h0);
    applyCycle(1'b1, 1'b1, 4'h7, 1'b0, 64'h999, 4'h9, 64'h777);
    idle(1'b0);
    checks++;
    if ({bus.f_valid, bus.imem_addr, bus.f_icode, bus.f_rA, bus.f_rB, bus.f_valC, bus.f_valP, bus.f_predPC} !==
        {1'b1, 64'h100, 4'h3, 4'hF, 4'h3, 64'h1122334455667788, 64'h10A, 64'h10A}) begin
      errors++;
      $display("FAIL reset_irmovq act=%h", actFull());
    end
    checks++;
    if (actFull() !== expFull) begin
      errors++;
      $display("FAIL reset_model act=%h exp=%h", actFull(), expFull);
    end
    idle(1'b0);
    checks++;
    if (bus.imem_addr !== 64'h10A) begin
      errors++;
      $display("FAIL reset_next_pc act=%h exp=%h", bus.imem_addr, 64'h10A);
    end
  endtask

  task automatic test_mispredict();
    putBytes(64'h200, 80'h00000000000003_0070, 9);
    putBytes(64'h209, 80'h1260, 2);
    jumpTo(1'b0, 64'h200);
    checks++;
    if ({bus.f_icode, bus.f_valC, bus.f_predPC} !== {4'h7, 64'h300, 64'h300}) begin
      errors++;
      $display("FAIL jxx_predict act=%h", actFull());
    end
    idle(1'b0);
    checks++;
    if (bus.imem_addr !== 64'h300) begin
      errors++;
      $display("FAIL jxx_taken_fetch act=%h exp=%h", bus.imem_addr, 64'h300);
    end
    jumpTo(1'b0, 64'h209);
    checks++;
    if (bus.imem_addr !== 64'h209 || actFull() !== expFull) begin
      errors++;
      $display("FAIL mispredict_recover act=%h exp=%h", actFull(), expFull);
    end
    idle(1'b0);
    checks++;
    if (bus.imem_addr !== 64'h20B) begin
      errors++;
      $display("FAIL after_recover act=%h exp=%h", bus.imem_addr, 64'h20B);
    end
  endtask

  task automatic test_ret();
    putBytes(64'h40, 80'h90, 1);
    jumpTo(1'b0, 64'h40);
    checks++;
    if ({bus.f_icode, bus.f_valP, bus.f_predPC} !== {4'h9, 64'h41, 64'h41}) begin
      errors++;
      $display("FAIL ret_fetch act=%h", actFull());
    end
    idle(1'b0);
    idle(1'b0);
    applyCycle(1'b0, 1'b0, 4'h7, 1'b0, 64'h70, 4'h9, 64'h88);
    checks++;
    if (bus.imem_addr !== 64'h70) begin
      errors++;
      $display("FAIL mispredict_over_ret act=%h exp=%h", bus.imem_addr, 64'h70);
    end
    applyCycle(1'b0, 1'b0, 4'h6, 1'b0, 64'h70, 4'h9, 64'h88);
    checks++;
    if (bus.imem_addr !== 64'h88 || actFull() !== expFull) begin
      errors++;
      $display("FAIL ret_redirect act=%h exp=%h", actFull(), expFull);
    end
  endtask

  task automatic test_halt();
    putBytes(64'h50, 80'h00, 1);
    jumpTo(1'b0, 64'h50);
    checks++;
    if ({bus.f_valid, bus.f_stat} !== {1'b1, 2'd1}) begin
      errors++;
      $display("FAIL halt_fetch act=%h", actFull());
    end
    for (int i = 0; i < 3; i++) begin
      idle(1'b0);
      checks++;
      if (actShort() !== {1'b0, 2'd0, 4'h1, 64'h51}) begin
        errors++;
        $display("FAIL halt_bubble[%0d] act=%h exp=%h", i, actShort(), expShort);
      end
    end
    jumpTo(1'b0, 64'h60);
    checks++;
    if (bus.f_valid !== 1'b1 || bus.imem_addr !== 64'h60 || actFull() !== expFull) begin
      errors++;
      $display("FAIL halt_revive act=%h exp=%h", actFull(), expFull);
    end
    idle(1'b0);
    checks++;
    if ({bus.f_valid, bus.imem_addr} !== {1'b1, 64'h61}) begin
      errors++;
      $display("FAIL run_after_revive act=%h", actShort());
    end
  endtask

  task automatic test_faults();
    putBytes(64'h80, 80'hC0, 1);
    jumpTo(1'b0, 64'h80);
    checks++;
    if ({bus.f_valid, bus.f_stat} !== {1'b1, 2'd3}) begin
      errors++;
      $display("FAIL invalid_instr act=%h", actFull());
    end
    idle(1'b0);
    checks++;
    if (bus.f_valid !== 1'b0) begin
      errors++;
      $display("FAIL halt_after_ins act=%h exp=0", bus.f_valid);
    end
    jumpTo(1'b0, 64'hE000_0000_0000_0010);
    checks++;
    if ({bus.f_valid, bus.f_stat, bus.f_icode} !== {1'b1, 2'd2, 4'h1} || actFull() !== expFull) begin
      errors++;
      $display("FAIL imem_error act=%h exp=%h", actFull(), expFull);
    end
    idle(1'b0);
    checks++;
    if (actShort() !== {1'b0, 2'd0, 4'h1, 64'hE000_0000_0000_0011}) begin
      errors++;
      $display("FAIL halt_after_adr act=%h exp=%h", actShort(), expShort);
    end
  endtask

  task automatic test_stall_wrap();
    jumpTo(1'b0, 64'h400);
    for (int i = 0; i < 3; i++) begin
      idle(1'b1);
      checks++;
      if (bus.imem_addr !== 64'h401 || actFull() !== expFull) begin
        errors++;
        $display("FAIL stall_hold[%0d] act=%h exp=%h", i, actFull(), expFull);
      end
    end
    jumpTo(1'b1, 64'h500);
    checks++;
    if (bus.imem_addr !== 64'h500) begin
      errors++;
      $display("FAIL stall_redirect act=%h exp=%h", bus.imem_addr, 64'h500);
    end
    idle(1'b0);
    checks++;
    if (bus.imem_addr !== 64'h401) begin
      errors++;
      $display("FAIL stall_release act=%h exp=%h", bus.imem_addr, 64'h401);
    end
    jumpTo(1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
    checks++;
    if ({bus.f_valP, bus.f_predPC} !== 128'h0) begin
      errors++;
      $display("FAIL valp_wrap act=%h exp=0", {bus.f_valP, bus.f_predPC});
    end
    idle(1'b0);
    checks++;
    if (bus.imem_addr !== 64'h0) begin
      errors++;
      $display("FAIL wrap_fetch act=%h exp=0", bus.imem_addr);
    end
    jumpTo(1'b0, 64'h50);
    idle(1'b0);
    applyCycle(1'b1, 1'b1, 4'h0, 1'b1, 64'h0, 4'h0, 64'h0);
    checks++;
    if (actShort() !== expShort) begin
      errors++;
      $display("FAIL halted_in_reset act=%h exp=%h", actShort(), expShort);
    end
    idle(1'b0);
    checks++;
    if ({bus.f_valid, bus.imem_addr} !== {1'b1, RPC}) begin
      errors++;
      $display("FAIL reset_from_halt act=%h", actShort());
    end
  endtask

  task automatic test_random();
    logic [63:0] tgt;
    logic [3:0]  mi, wi;
    bit          stall, mc;
    for (int a = 0; a < 256; a++)
      mem[64'h1000 + 64'(a)] = {4'($urandom_range(0, 12)), 4'($urandom)};
    for (int i = 0; i < 400; i++) begin
      tgt = ($urandom % 16 == 0) ? 64'hE000_0000_0000_0000 + 64'($urandom_range(0, 15))
                                 : 64'h1000 + 64'($urandom_range(0, 255));
      stall = ($urandom % 5 == 0);
      mi    = ($urandom % 6 == 0) ? 4'h7 : 4'($urandom);
      mc    = ($urandom % 2 == 0);
      wi    = ($urandom % 8 == 0) ? 4'h9 : 4'($urandom_range(0, 8));
      applyCycle(1'b0, stall, mi, mc, tgt, wi, 64'h1000 + 64'($urandom_range(0, 255)));
      checks++;
      if (actShort() !== expShort) begin
        errors++;
        $display("FAIL random_short[%0d] act=%h exp=%h", i, actShort(), expShort);
      end
      if (expActive) begin
        checks++;
        if (actFull() !== expFull) begin
          errors++;
          $display("FAIL random_full[%0d] act=%h exp=%h", i, actFull(), expFull);
        end
      end
    end
  endtask

  initial begin
    bus.f_stall    = 1'b0;
    bus.M_icode    = 4'h0;
    bus.M_cnd      = 1'b0;
    bus.M_valA     = 64'h0;
    bus.W_icode    = 4'h0;
    bus.W_valM     = 64'h0;
    bus.imem_data  = 80'h0;
    bus.imem_error = 1'b0;
    test_reset();
    test_mispredict();
    test_ret();
    test_halt();
    test_faults();
    test_stall_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
